// File: rtl/aes_ct_serializer.sv
// aes_ct_serializer: buffers 128-bit ciphertext blocks and streams them MSB-first as W-bit words.
module aes_ct_serializer #(
  parameter int DEPTH = 2,
  parameter int W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid,
  input  logic [127:0]               ct,
  output logic [W-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow
);
  localparam int N = 128 / W;
  localparam int AW = $clog2(DEPTH);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  logic [127:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [IW-1:0] idx;
  logic [127:0] head;
  logic hs, pop, push;
  // a pop frees its slot in the same cycle, so a full buffer can still accept
  always_comb begin
    out_valid = level != '0;
    hs = out_valid && out_ready;
    pop = hs && idx == IW'(N - 1);
    push = valid && (level < LW'(DEPTH) || pop);
    head = mem[rptr] << (int'(idx) * W);
    out_data = out_valid ? head[127 -: W] : '0;
    out_last = out_valid && idx == IW'(N - 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      idx <= '0;
      level <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      if (hs) idx <= pop ? '0 : idx + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (valid && !push) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= ct;
  end
endmodule

// File: tb/tb_aes_ct_serializer.sv
// tb_aes_ct_serializer: randomized and directed scoreboard bench for aes_ct_serializer.
module tb_aes_ct_serializer;
  typedef struct {logic [127:0] d; logic l;} exp_t;
  logic clk = 0, rst = 1, valid = 0, out_ready = 0, vaux = 0;
  logic [127:0] ct = '0, ct_aux = '0;
  logic [31:0] out_data;
  logic out_valid, out_last, overflow;
  logic [1:0] level;
  logic [7:0] d8;
  logic v8, l8, o8;
  logic [1:0] lv8;
  logic [127:0] d128;
  logic v128, l128, o128;
  logic [1:0] lv128;
  int tests = 0, fails = 0;
  exp_t q[$], q8[$], q128[$];
  exp_t e, e8, e128;
  bit ovf = 0, stall = 0;
  logic [31:0] held;
  logic [127:0] blk_a = 128'h3925841d02dc09fbdc118597196a0b32;
  logic [127:0] blk_p = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;

  aes_ct_serializer #(.DEPTH(2), .W(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ct(ct), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .level(level), .overflow(overflow));
  aes_ct_serializer #(.DEPTH(2), .W(8)) dut8 (
    .clk(clk), .rst(rst), .valid(vaux), .ct(ct_aux), .out_data(d8), .out_valid(v8),
    .out_ready(1'b1), .out_last(l8), .level(lv8), .overflow(o8));
  aes_ct_serializer #(.DEPTH(2), .W(128)) dut128 (
    .clk(clk), .rst(rst), .valid(vaux), .ct(ct_aux), .out_data(d128), .out_valid(v128),
    .out_ready(1'b1), .out_last(l128), .level(lv128), .overflow(o128));

  task automatic check(string name, logic [127:0] act, logic [127:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic spurious(string name);
    tests++;
    fails++;
    $display("FAIL %s: got a word expected none", name);
  endtask

  // Reference: the buffer holds ceil(pending_words/N) blocks; the monitor pops the
  // word queue before the edge, so a same-cycle pop is already reflected here.
  always @(posedge clk) begin
    if (!rst && valid) begin
      if ((q.size() + 3) / 4 < 2)
        for (int k = 0; k < 4; k++) q.push_back('{d: (ct << (k * 32)) >> 96, l: k == 3});
      else
        ovf = 1;
    end
    if (!rst && vaux) begin
      for (int k = 0; k < 16; k++) q8.push_back('{d: (ct_aux << (k * 8)) >> 120, l: k == 15});
      q128.push_back('{d: ct_aux, l: 1'b1});
    end
  end

  always @(negedge clk) begin
    if (rst) stall = 0;
    else begin
      check("level", level, (q.size() + 3) / 4);
      check("out_valid", out_valid, q.size() != 0);
      check("overflow", overflow, ovf);
      if (!out_valid) check("idle_data", out_data, 0);
      if (stall) check("stall_hold", out_data, held);
      if (out_valid && out_ready) begin
        if (q.size() == 0) spurious("word");
        else begin
          e = q.pop_front();
          check("word", out_data, e.d);
          check("last", out_last, e.l);
        end
      end
      stall = out_valid && !out_ready;
      held = out_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("w8_valid", v8, q8.size() != 0);
      check("w128_valid", v128, q128.size() != 0);
      if (v8) begin
        if (q8.size() == 0) spurious("w8_word");
        else begin
          e8 = q8.pop_front();
          check("w8_word", d8, e8.d);
          check("w8_last", l8, e8.l);
        end
      end
      if (v128) begin
        if (q128.size() == 0) spurious("w128_word");
        else begin
          e128 = q128.pop_front();
          check("w128_word", d128, e128.d);
          check("w128_last", l128, e128.l);
        end
      end
    end
  end

  task automatic step(bit v, logic [127:0] d, bit r);
    valid = v;
    ct = d;
    out_ready = r;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1;
    valid = 0;
    out_ready = 0;
    vaux = 0;
    q.delete();
    q8.delete();
    q128.delete();
    ovf = 0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_level", level, 0);
    check("rst_overflow", overflow, 0);
    check("rst_last", out_last, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    check("init_valid", out_valid, 0);
    check("init_level", level, 0);
    check("init_data", out_data, 0);
    check("init_overflow", overflow, 0);
    rst = 0;
    step(1, blk_a, 1);
    check("first_word", out_data, 32'h3925841d);
    repeat (6) step(0, 0, 1);
    step(1, blk_a, 0);
    repeat (5) step(0, 0, 0);
    check("bp_hold", out_data, 32'h3925841d);
    repeat (6) step(0, 0, 1);
    do_reset();
    step(1, blk_a, 0);
    step(1, {4{$urandom}}, 0);
    step(1, {4{$urandom}}, 0);
    check("burst_overflow", overflow, 1);
    check("burst_level", level, 2);
    repeat (10) step(0, 0, 1);
    do_reset();
    step(1, blk_a, 0);
    step(1, {$urandom, $urandom, $urandom, $urandom}, 0);
    repeat (3) step(0, 0, 1);
    step(1, {$urandom, $urandom, $urandom, $urandom}, 1);
    check("swap_level", level, 2);
    check("swap_overflow", overflow, 0);
    repeat (10) step(0, 0, 1);
    do_reset();
    step(1, blk_a, 0);
    step(1, {$urandom, $urandom, $urandom, $urandom}, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    do_reset();
    step(1, {$urandom, $urandom, $urandom, $urandom}, 1);
    repeat (6) step(0, 0, 1);
    vaux = 1;
    ct_aux = blk_p;
    @(posedge clk);
    #2 vaux = 0;
    check("w128_out", d128, blk_p);
    repeat (20) step(0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) do_reset();
      step($urandom % 3 == 0, {$urandom, $urandom, $urandom, $urandom}, $urandom % 4 != 0);
    end
    repeat (20) step(0, 0, 1);
    check("drain_main", q.size(), 0);
    check("drain_w8", q8.size(), 0);
    check("drain_w128", q128.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
